// File: rtl/rand_pool_n3k32.sv
// Double-buffered randomness pool for the 3-share 32-bit secure Kogge-Stone adder.
// RNG words are packed into one 960-bit bank while the other bank, once complete,
// is presented on o_n. Used banks are zeroised on release so randomness is never reused.
module rand_pool_n3k32 #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 30
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        rng_valid_i,
    input  logic [WORD_W-1:0]           rng_data_i,
    output logic                        rng_ready_o,
    input  logic                        flush_i,
    input  logic                        take_i,
    output logic [WORD_W*NUM_WORDS-1:0] o_n,
    output logic                        o_rvld,
    output logic                        o_starve
);

    localparam int VEC_W = WORD_W * NUM_WORDS;
    localparam int CNT_W = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [VEC_W-1:0] bank_q [2];
    logic [VEC_W-1:0] bank_d [2];
    logic [1:0]       full_q;
    logic [1:0]       full_d;
    logic             wr_bank_q;
    logic             wr_bank_d;
    logic             rd_bank_q;
    logic             rd_bank_d;
    logic [CNT_W-1:0] wcnt_q;
    logic [CNT_W-1:0] wcnt_d;
    logic             rdy_q;
    logic             rdy_d;
    logic             starve_q;
    logic             starve_d;
    logic             accept_s;
    logic             take_s;

    // Next-state: flush dominates; otherwise fill and release act on different banks.
    always_comb begin
        bank_d    = bank_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wcnt_d    = wcnt_q;
        starve_d  = starve_q;
        accept_s  = rng_valid_i && rdy_q;
        take_s    = take_i && full_q[rd_bank_q];

        if (flush_i) begin
            bank_d[0] = '0;
            bank_d[1] = '0;
            full_d    = 2'b00;
            wcnt_d    = '0;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
        end else begin
            if (accept_s) begin
                bank_d[wr_bank_q][WORD_W*int'(wcnt_q) +: WORD_W] = rng_data_i;
                if (wcnt_q == LAST_WORD) begin
                    full_d[wr_bank_q] = 1'b1;
                    wcnt_d            = '0;
                    wr_bank_d         = ~wr_bank_q;
                end else begin
                    wcnt_d = wcnt_q + CNT_ONE;
                end
            end else begin
                wcnt_d = wcnt_q;
            end

            // A full write bank can never be the bank being released, so no overlap here.
            if (take_s) begin
                full_d[rd_bank_q] = 1'b0;
                bank_d[rd_bank_q] = '0;
                rd_bank_d         = ~rd_bank_q;
            end else if (take_i) begin
                starve_d = 1'b1;
            end else begin
                starve_d = starve_q;
            end
        end

        // Ready looks at the bank that will be written after this edge.
        rdy_d = !full_d[wr_bank_d] && !flush_i;
    end

    // State register; asynchronous reset zeroises every bank.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wcnt_q    <= '0;
            rdy_q     <= 1'b0;
            starve_q  <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wcnt_q    <= wcnt_d;
            rdy_q     <= rdy_d;
            starve_q  <= starve_d;
        end
    end

    // Outputs come straight from state; a partial bank is never visible.
    always_comb begin
        rng_ready_o = rdy_q;
        o_rvld      = full_q[rd_bank_q];
        o_starve    = starve_q;
        if (full_q[rd_bank_q]) begin
            o_n = bank_q[rd_bank_q];
        end else begin
            o_n = '0;
        end
    end

endmodule

// File: tb/tb_rand_pool_n3k32.sv
// Directed bench for rand_pool_n3k32. Stimulus pushes each completed vector into a
// scoreboard queue; a monitor pops and compares whenever the consumer takes a vector.
module tb_rand_pool_n3k32;

    localparam int VW = 960;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rng_valid_i = 1'b0;
    logic [31:0]   rng_data_i = 32'h0;
    logic          rng_ready_o;
    logic          flush_i = 1'b0;
    logic          take_i = 1'b0;
    logic [VW-1:0] o_n;
    logic          o_rvld;
    logic          o_starve;

    int total = 0;
    int bad   = 0;
    logic [VW-1:0] exp_q [$];

    rand_pool_n3k32 dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rng_valid_i (rng_valid_i),
        .rng_data_i  (rng_data_i),
        .rng_ready_o (rng_ready_o),
        .flush_i     (flush_i),
        .take_i      (take_i),
        .o_n         (o_n),
        .o_rvld      (o_rvld),
        .o_starve    (o_starve)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [VW-1:0] mkvec(input logic [31:0] base);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < 30; k++) v[32*k +: 32] = base + 32'(k);
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a word until the pool accepts it, with a bounded wait.
    task automatic feed_word(input logic [31:0] d);
        int   n;
        logic acc;
        n = 0;
        rng_valid_i = 1'b1;
        rng_data_i  = d;
        do begin
            acc = rng_ready_o;
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL feed_timeout: got no accept expected accept of %h", d);
        end
        rng_valid_i = 1'b0;
        rng_data_i  = 32'hDEAD_BEEF;
    endtask

    task automatic feed_n(input logic [31:0] base, input int cnt);
        for (int k = 0; k < cnt; k++) feed_word(base + 32'(k));
    endtask

    task automatic take_pulse();
        take_i = 1'b1;
        tick();
        take_i = 1'b0;
    endtask

    // Monitor: compare presented vector at every consumption; idle output must be zero.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (take_i && o_rvld) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got vector %h expected none", o_n);
                end else begin
                    chkv("sb_vector", o_n, exp_q.pop_front());
                end
            end
            if (!o_rvld) chkv("idle_zero", o_n, '0);
        end
    end

    initial begin
        // Reset state
        #2;
        chk1("rst_ready", rng_ready_o, 1'b0);
        chk1("rst_rvld", o_rvld, 1'b0);
        chk1("rst_starve", o_starve, 1'b0);
        chkv("rst_n", o_n, '0);
        tick();
        tick();
        rst_ni = 1'b1;
        chk1("ready_before_edge", rng_ready_o, 1'b0);
        tick();
        chk1("ready_after_release", rng_ready_o, 1'b1);

        // 1: words 0..29 form the first vector
        feed_n(32'h0, 29);
        chk1("t1_rvld_29", o_rvld, 1'b0);
        feed_word(32'd29);
        chk1("t1_rvld_30", o_rvld, 1'b1);
        exp_q.push_back(mkvec(32'h0));

        // 2: second bank fills, then back-pressure holds word 60
        feed_n(32'd30, 30);
        exp_q.push_back(mkvec(32'd30));
        chk1("t2_ready_both_full", rng_ready_o, 1'b0);
        rng_valid_i = 1'b1;
        rng_data_i  = 32'd60;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("t2_held_ready", rng_ready_o, 1'b0);
        end
        take_pulse();
        chk1("t2_ready_back", rng_ready_o, 1'b1);
        chk1("t2_rvld_kept", o_rvld, 1'b1);
        feed_n(32'd60, 30);
        exp_q.push_back(mkvec(32'd60));
        chk1("t2_ready_full_again", rng_ready_o, 1'b0);

        // 3: fill-complete and take on the same edge
        take_pulse();
        feed_n(32'h100, 29);
        chk1("t3_ready_pre", rng_ready_o, 1'b1);
        rng_valid_i = 1'b1;
        rng_data_i  = 32'h100 + 32'd29;
        take_i      = 1'b1;
        exp_q.push_back(mkvec(32'h100));
        tick();
        rng_valid_i = 1'b0;
        take_i      = 1'b0;
        chk1("t3_rvld_stays", o_rvld, 1'b1);
        chkv("t3_bank_b", o_n, mkvec(32'h100));
        feed_n(32'h200, 30);
        exp_q.push_back(mkvec(32'h200));
        take_pulse();
        take_pulse();
        chk1("t3_rvld_empty", o_rvld, 1'b0);

        // 4: starvation is sticky and disturbs nothing
        chk1("t4_starve_pre", o_starve, 1'b0);
        take_pulse();
        chk1("t4_starve_set", o_starve, 1'b1);
        tick();
        tick();
        chk1("t4_starve_sticky", o_starve, 1'b1);
        feed_n(32'h300, 30);
        exp_q.push_back(mkvec(32'h300));
        chk1("t4_rvld", o_rvld, 1'b1);
        take_pulse();

        // 5: flush discards a partial fill
        feed_n(32'h400, 17);
        chk1("t5_partial_hidden", o_rvld, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk1("t5_flush_ready0", rng_ready_o, 1'b0);
        chk1("t5_flush_rvld0", o_rvld, 1'b0);
        tick();
        chk1("t5_ready_return", rng_ready_o, 1'b1);
        chk1("t5_starve_kept", o_starve, 1'b1);
        feed_n(32'hA5A5_0000, 29);
        chk1("t5_rvld_29", o_rvld, 1'b0);
        feed_word(32'hA5A5_001D);
        chk1("t5_rvld_30", o_rvld, 1'b1);
        exp_q.push_back(mkvec(32'hA5A5_0000));
        take_pulse();

        // 6: asynchronous reset with one full bank and a partial one
        feed_n(32'h500, 30);
        feed_n(32'h600, 12);
        chk1("t6_rvld_pre", o_rvld, 1'b1);
        #2;
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        chk1("t6_rvld_async", o_rvld, 1'b0);
        chkv("t6_n_async", o_n, '0);
        chk1("t6_starve_cleared", o_starve, 1'b0);
        tick();
        rst_ni = 1'b1;
        tick();
        feed_n(32'h700, 29);
        chk1("t6_rvld_29", o_rvld, 1'b0);
        feed_word(32'h700 + 32'd29);
        chk1("t6_rvld_30", o_rvld, 1'b1);
        exp_q.push_back(mkvec(32'h700));
        take_pulse();

        tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
